// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract, one CHUNK-bit carry segment resolved per register stage
module adder_pipe #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int STAGES = WIDTH / CHUNK;
   localparam int L = STAGES - 1;
   logic adv;
   assign adv = !out_valid || out_ready;
   assign in_ready = adv;
   for (genvar k = 0; k < STAGES; k++) begin : g
      localparam int REM = WIDTH - k * CHUNK;
      logic [REM-1:0] ax, bx;
      logic [(k+1)*CHUNK-1:0] sn, sr;
      logic cx, vx, cr, vr;
      logic [CHUNK:0] p;
      // Subtraction is folded in at entry: B and carry-in are inverted once, then skewed as-is
      if (k == 0) begin : src
         assign ax = a;
         assign bx = sub ? ~b : b;
         assign cx = sub ? ~cin : cin;
         assign vx = in_valid;
         assign sn = p[CHUNK-1:0];
      end else begin : src
         assign ax = g[k-1].sk.ar;
         assign bx = g[k-1].sk.br;
         assign cx = g[k-1].cr;
         assign vx = g[k-1].vr;
         assign sn = {p[CHUNK-1:0], g[k-1].sr};
      end
      assign p = {1'b0, ax[CHUNK-1:0]} + {1'b0, bx[CHUNK-1:0]} + {{CHUNK{1'b0}}, cx};
      always_ff @(posedge clk)
         if (rst) begin
            sr <= '0;
            cr <= 1'b0;
            vr <= 1'b0;
         end else if (adv) begin
            sr <= sn;
            cr <= p[CHUNK];
            vr <= vx;
         end
      if (k < L) begin : sk
         logic [REM-CHUNK-1:0] ar, br;
         always_ff @(posedge clk)
            if (rst) begin
               ar <= '0;
               br <= '0;
            end else if (adv) begin
               ar <= ax[REM-1:CHUNK];
               br <= bx[REM-1:CHUNK];
            end
      end
   end
   assign out_valid = g[L].vr;
   assign sum = g[L].sr;
   assign cout = g[L].cr;
   always_ff @(posedge clk)
      if (rst) ovf <= 1'b0;
      else if (adv) ovf <= (g[L].ax[CHUNK-1] == g[L].bx[CHUNK-1]) && (g[L].p[CHUNK-1] != g[L].ax[CHUNK-1]);
endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract unit that replaces the fixed 4-bit combinational adder block wherever wider operands or higher clock rates are needed. The WIDTH-bit carry chain is cut into CHUNK-bit segments with one register stage per segment, so there is one CHUNK-bit ripple per cycle. A valid/ready handshake sits on both sides, with a global pipeline stall. The block adds a subtract mode and a signed-overflow flag.

## Interface
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK, derived, ≥1.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A, unsigned / two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (add); NOT-borrow (sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow of the result.

## Operation
- Sub mode is computed as a + ~b + ~cin. cout is the raw carry out of bit WIDTH−1.
- ovf = (a_msb' == b_msb') && (sum_msb != a_msb'), where b_msb' is the MSB of the effective (inverted when sub=1) B operand.
- Stage k (0..STAGES−1) adds chunk k of A and effective B plus the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Input skew: chunk k of A/B is delayed k cycles before stage k uses it.
- Output deskew: sum chunk k is delayed STAGES−1−k cycles, so all chunks of one beat emerge together.
- sub and the per-beat valid bit travel with the beat through every stage.
- Advance condition: adv = !out_valid || out_ready.
  - When adv=1, every stage register, including the valid bits, shifts by one.
  - When adv=0, every register holds.
- in_ready = adv, combinational from out_valid and out_ready.
- A beat is accepted when in_valid && in_ready.
- When in_ready=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- sum/cout/ovf are registered and held stable while out_valid && !out_ready.
- Outputs are don't-care when out_valid=0, but must not contain X after reset.

## Timing
- Reset, on the clk edge with rst=1:
  - All valid bits clear, so out_valid=0 and in_ready=1 from the next cycle.
  - sum=0, cout=0, ovf=0, and all internal data/carry registers are 0.
- rst overrides a simultaneous handshake. Beats in flight during reset are discarded and never appear on the output.
- Latency: a beat accepted at edge t has out_valid=1 after edge t+STAGES−1, i.e. it is visible in the cycle following STAGES edges from acceptance.
  - WIDTH=CHUNK gives a single register stage, latency 1.
- Throughput: one beat per cycle with out_ready held 1. No bubbles are inserted.
- Stall: when out_valid=1 and out_ready=0, in_ready=0 in the same cycle and the whole pipe freezes. Zero beats are lost or duplicated.
- Simultaneous events:
  - out_ready rising in the same cycle as in_valid lets the beat be accepted and the head beat retire on the same edge.
  - Full pipe plus out_ready=1 plus in_valid=1 is a steady state.
- Wrap-around: the result is modulo 2^WIDTH. cout/ovf report the wrap, and no saturation is applied.

## Test plan
- Default parameters, add 0x00FF+0x0001, cin=0 → sum=0x0100, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance (carry crosses a chunk boundary).
- Add 0xFFFF+0x0001 → 0x0000, cout=1, ovf=0.
- Add 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1.
- Sub, then a second sub beat:
  - 0x0003−0x0002, cin=0 → 0x0001, cout=1, ovf=0.
  - 0x0000−0x0001 → 0xFFFF, cout=0.
  - 0x8000−0x0001 → 0x7FFF, ovf=1.
- Stream 20 random beats back-to-back while out_ready toggles pseudo-randomly → in-order results match the reference model, none lost or duplicated.
  - sum/cout/ovf stay stable during every stall.
  - rst asserted mid-stream → out_valid=0 next cycle, and no pre-reset beat appears.
- WIDTH=4, CHUNK=4: a=3, b=2, cin=0 → sum=5, cout=0, latency 1.
- WIDTH=32, CHUNK=8: 0xFFFFFFFF+0+cin=1 → 0, cout=1, latency 4.
